// File: rtl/tagged_value_serializer_if.sv
// Handshake bundle for the tagged value serializer: a wide value input port and a byte-wide stream output port.
interface tagged_value_serializer_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_tag;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  modport master (
    output in_valid, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/tagged_value_serializer.sv
// Serializes one tagged integer (1/2/4/8 bytes) per transaction into a little-endian byte stream,
// optionally prefixed by a header byte carrying the tag, and counts completed frames.
module tagged_value_serializer #(
  parameter bit EMIT_HEADER = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tagged_value_serializer_if.slave  bus,
  output logic [CNT_W-1:0]          frame_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        tag_q, tag_d;
  logic [63:0]       data_q, data_d;
  logic [2:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        last_idx;

  // Index of the final payload byte: (1 << tag) - 1
  always_comb begin
    case (tag_q)
      2'd0:    last_idx = 3'd0;
      2'd1:    last_idx = 3'd1;
      2'd2:    last_idx = 3'd3;
      default: last_idx = 3'd7;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          tag_d   = bus.in_tag;
          data_d  = bus.in_data;
          idx_d   = 3'd0;
          state_d = EMIT_HEADER ? S_HEADER : S_PAYLOAD;
        end
      end
      S_HEADER: begin
        if (bus.out_ready) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (bus.out_ready) begin
          if (idx_q == last_idx) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded purely from registered state, so they hold steady under backpressure
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.out_last  = 1'b0;
    case (state_q)
      S_HEADER: begin
        bus.out_valid = 1'b1;
        bus.out_data  = {4'hA, 2'b00, tag_q};
      end
      S_PAYLOAD: begin
        bus.out_valid = 1'b1;
        bus.out_data  = data_q[{idx_q, 3'b000} +: 8];
        bus.out_last  = (idx_q == last_idx);
      end
      default: ;
    endcase
  end

  assign frame_count = cnt_q;

endmodule

// File: doc/tagged_value_serializer.md
# tagged_value_serializer

Serializes one tagged integer value (byte, shortint, int or longint) per transaction into a little-endian byte stream with an optional header byte. It sits directly downstream of the modules that carry integer-atom typed ports. It converts their wide values into a byte-wide valid/ready link for transport or logging. One frame is emitted per accepted input, and a running frame counter is exposed.

## Interface
- EMIT_HEADER, 1: 1 = prefix each frame with a header byte; 0 = payload bytes only.
- CNT_W, 16: width of frame_count.
- clk  input  1  sole clock; all logic is rising-edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  input value present.
- in_ready  output  1  block can accept a value.
- in_tag  input  2  type tag: 0 = byte (1 B), 1 = shortint (2 B), 2 = int (4 B), 3 = longint (8 B).
- in_data  input  64  value. Only the low 1/2/4/8 bytes per tag are used; upper bits are ignored; signedness is irrelevant.
- out_valid  output  1  out_data holds a byte.
- out_ready  input  1  downstream accepts the byte.
- out_data  output  8  stream byte.
- out_last  output  1  marks the final byte of a frame.
- frame_count  output  CNT_W  count of completed frames; wraps.

## Operation
- States: IDLE, HEADER, PAYLOAD.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_tag and in_data, and load byte index = 0.
  - Next state is HEADER if EMIT_HEADER = 1, else PAYLOAD.
- HEADER:
  - out_valid = 1, out_data = {4'hA, 2'b00, tag}, out_last = 0.
  - On out_ready, go to PAYLOAD.
- PAYLOAD:
  - out_valid = 1, out_data = captured byte[index].
  - Byte 0 is the LSB.
  - out_last = 1 when index = N-1, where N = 1 << tag.
  - On out_ready with index < N-1: index increments.
  - On out_ready with index = N-1: frame_count increments and the state returns to IDLE.
- in_ready = (state == IDLE). It is combinational from state, so it reads 1 during reset. No capture occurs while rst_n is low.
- in_data and in_tag are sampled only at capture. Later changes do not affect the frame in flight.
- frame_count is modulo 2^CNT_W: 0xFFFF + 1 = 0x0000 at the default width.
- Reset values:
  - state = IDLE.
  - out_valid = 0, out_data = 0x00, out_last = 0.
  - frame_count = 0.
  - Captured registers = 0.
- Reset mid-frame: the frame is abandoned. No count is recorded and no further bytes are emitted. After release, the next frame starts cleanly.

## Timing
- Capture edge → out_valid = 1 on the next cycle (1-cycle latency to the first byte).
- Each byte is held stable (data, last, valid) while out_valid & !out_ready. out_valid never drops without a transfer.
- One byte is transferred per cycle when out_ready is held high.
- Frame period with continuous in_valid and out_ready: 1 + N + EMIT_HEADER cycles. Example: longint with header takes 10 cycles.
- The last-byte transfer and the return to IDLE occur on the same edge. in_ready rises in the following cycle.
- frame_count updates on the edge of the last-byte transfer and is visible the next cycle.
- out_ready low in IDLE has no effect. in_valid while not IDLE is ignored: no capture, and the upstream holds its value.

## Test plan
- Reset check: assert rst_n = 0 with random inputs.
  - Required: out_valid = 0, out_data = 0x00, out_last = 0, frame_count = 0, in_ready = 1.
- Byte frame: tag = 0, data = 0x...12, EMIT_HEADER = 1, out_ready = 1.
  - Required stream: 0xA0, 0x12 (last).
  - frame_count = 1.
  - The frame occupies 3 cycles from capture to the next in_ready.
- Longint ordering: tag = 3, data = 0x0807060504030201.
  - Required stream: 0xA3, then 01 02 03 04 05 06 07 08, with out_last only on 08.
- Backpressure: tag = 2, data = 0xDEADBEEF, with out_ready toggled pseudo-randomly.
  - Required: bytes 0xA2, EF, BE, AD, DE, each stable while stalled.
  - No duplicates or drops; in_ready stays 0 until the final transfer.
- Headerless build with wrap: EMIT_HEADER = 0, CNT_W = 4, 17 shortint frames of 0x1234.
  - Required: each frame is 34 12 (last).
  - frame_count reads 0xF after 15 frames, 0x0 after 16, and 0x1 after 17.
- Reset mid-frame: pulse rst_n low after the 3rd byte of a longint frame, then send a byte frame 0x55.
  - Required: outputs take reset values immediately.
  - The next stream is 0xA0, 0x55, and frame_count = 1.
